// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with architectural HI/LO registers.
// Operands and opcode are latched on an accepted start. The result is
// committed to HI/LO together on the edge where busy falls.
// Optional build macro: MD_DIVZERO_KEEP_EN. When it is defined, a div/divu by
// zero leaves HI/LO unchanged. When it is undefined (the default), a div/divu
// by zero writes lo=0xFFFFFFFF and hi=a.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES);

  state_t      state;
  logic [4:0]  cnt;
  logic [1:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;

  logic        accept;
  logic [63:0] sprod;
  logic [63:0] uprod;
  logic [31:0] ua, ub, uq, ur;
  logic [31:0] res_hi, res_lo;
  logic        res_wr;

  assign accept = (state == IDLE) && start && !flush;
  assign stall  = busy | start;

  // Result datapath, evaluated from the latched operands
  always_comb begin
    sprod  = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    uprod  = {32'b0, a_q} * {32'b0, b_q};
    // Signed divide is done on magnitudes, with the signs fixed up afterwards.
    // The 0x80000000 / -1 case falls out naturally as lo=0x80000000, hi=0.
    ua     = (op_q[0] == 1'b0 && a_q[31]) ? -a_q : a_q;
    ub     = (op_q[0] == 1'b0 && b_q[31]) ? -b_q : b_q;
    uq     = (ub == '0) ? '0 : ua / ub;
    ur     = (ub == '0) ? '0 : ua % ub;
    res_hi = '0;
    res_lo = '0;
    res_wr = 1'b1;
    case (op_q)
      2'b00: {res_hi, res_lo} = sprod;
      2'b01: {res_hi, res_lo} = uprod;
      2'b10: begin
        res_lo = (a_q[31] ^ b_q[31]) ? -uq : uq;
        res_hi = a_q[31] ? -ur : ur;
      end
      default: begin
        res_lo = uq;
        res_hi = ur;
      end
    endcase
    if (op_q[1] && (b_q == '0)) begin
`ifdef MD_DIVZERO_KEEP_EN
      res_wr = 1'b0;
`else
      res_lo = '1;
      res_hi = a_q;
`endif
    end
  end

  // IDLE/BUSY control, operand latch, cycle counter and HI/LO registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= BUSY;
            busy  <= 1'b1;
            cnt   <= op[1] ? DIV_LOAD : MULT_LOAD;
            op_q  <= op;
            a_q   <= a;
            b_q   <= b;
          end else if (!start) begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        default: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (cnt <= 5'd1) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            if (res_wr) begin
              hi <= res_hi;
              lo <= res_lo;
            end
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed vector table plus hand-written multi-cycle sequences
// for md_unit with default parameters (5 mult cycles, 10 div cycles).
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset, start, mthi, mtlo, flush;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .flush(flush),
    .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one operation and count busy cycles (bounded); returns at the
  // first negedge after busy falls.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int cyc, output logic stall_last);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    stall_last = 1'b0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      stall_last = stall;
      @(negedge clk);
    end
  endtask

  initial begin
    int   cyc;
    logic sl;

    tbl[0] = '{"mult -2*3",      2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    tbl[1] = '{"multu max*max",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    tbl[2] = '{"div -7/2",       2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    tbl[3] = '{"div ovf",        2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    tbl[4] = '{"divu 100/7",     2'b11, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
    tbl[5] = '{"mult 7*-5",      2'b00, 32'h00000007, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFDD, 5};
    tbl[6] = '{"div 7/-2",       2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
`ifdef MD_DIVZERO_KEEP_EN
    tbl[7] = '{"divu 5/0 keep",  2'b11, 32'd5,        32'd0,        32'h00000001, 32'hFFFFFFFD, 10};
`else
    tbl[7] = '{"divu 5/0",       2'b11, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 10};
`endif
    tbl[8] = '{"multu 2^16*2^16", 2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};

    reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; flush = 1'b0;
    op = '0; a = '0; b = '0; wdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset stall", {31'b0, stall}, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);

    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, cyc, sl);
      check({tbl[i].name, " cycles"}, 32'(cyc), 32'(tbl[i].cyc));
      check({tbl[i].name, " stall last"}, {31'b0, sl}, 32'd1);
      check({tbl[i].name, " hi"}, hi, tbl[i].hi);
      check({tbl[i].name, " lo"}, lo, tbl[i].lo);
    end

    // Second start and mthi during busy cycle 2 are both ignored
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
    mthi = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    cyc = 2;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    check("ignored start cycles", 32'(cyc), 32'd5);
    check("ignored start hi", hi, 32'd0);
    check("ignored start lo", lo, 32'd12);
    repeat (3) @(negedge clk);
    check("ignored start idle", {31'b0, busy}, 32'd0);

    // Flush at busy cycle 3 of divu 100/7, then moves while idle
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", {31'b0, busy}, 32'd0);
    check("flush hi", hi, 32'd0);
    check("flush lo", lo, 32'd12);
    mtlo = 1'b1; wdata = 32'hABCD;
    @(negedge clk);
    mtlo = 1'b0;
    check("mtlo lo", lo, 32'hABCD);
    check("mtlo hi", hi, 32'd0);
    mthi = 1'b1; wdata = 32'h5555;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi hi", hi, 32'h5555);
    check("mthi lo", lo, 32'hABCD);

    // Start and mtlo together: start wins, move dropped
    start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd2; mtlo = 1'b1; wdata = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; mtlo = 1'b0;
    check("start+mtlo busy", {31'b0, busy}, 32'd1);
    check("start+mtlo lo held", lo, 32'hABCD);
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    check("start+mtlo cycles", 32'(cyc), 32'd5);
    check("start+mtlo hi", hi, 32'd0);
    check("start+mtlo lo", lo, 32'd4);

    // Flush with start while idle suppresses acceptance
    start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
    #1;
    check("start stall comb", {31'b0, stall}, 32'd1);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush+start busy", {31'b0, busy}, 32'd0);
    repeat (6) @(negedge clk);
    check("flush+start lo", lo, 32'd4);

    // Reset at busy cycle 4 discards the operation
    mthi = 1'b1; wdata = 32'h77;
    @(negedge clk);
    mthi = 1'b0;
    check("pre-reset hi", hi, 32'h77);
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("op reset busy", {31'b0, busy}, 32'd0);
    check("op reset hi", hi, 32'd0);
    check("op reset lo", lo, 32'd0);
    repeat (12) @(negedge clk);
    check("post reset busy", {31'b0, busy}, 32'd0);
    check("post reset hi", hi, 32'd0);
    check("post reset lo", lo, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
